multicycle_control_unit: RTL and testbench
==========================================

# multicycle_control_unit

- Successor to the single-cycle control decoder: an FSM that sequences a multicycle RV32I datapath.
- Each instruction runs through fetch, decode, execute, memory and writeback over several cycles.
- Per-cycle datapath strobes are generated from the current state and opcode, and the FSM waits on a shared instruction/data memory ready handshake.
- Memory stalls are bounded by a timeout counter. Retirement, halt and error are reported.

## Interface
- `MEM_TIMEOUT`, 15: maximum consecutive not-ready cycles in a memory state before error; 0 disables the timeout.
- `PERF_WIDTH`, 32: width of the performance counters.
- `clk` in 1: the single clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-low (asserted when 0).
- `opcode` in 7: IR[6:0]; valid from the ID state onward.
- `alu_bcond` in 1: branch condition from the ALU, valid in EX.
- `mem_ready` in 1: the memory has completed the current read or write.
- `halt_req` in 1: ecall halt condition (x17==10), sampled in ID.
- `i_or_d` out 1: memory address select; 0=PC, 1=ALUOut.
- `mem_read` out 1, `mem_write` out 1: memory strobes.
- `ir_write` out 1: IR and MDR load enable.
- `alu_src_a` out 1: 0=PC, 1=rs1.
- `alu_src_b` out 2: 0=rs2, 1=const 4, 2=imm.
- `alu_op` out 2: 00=add, 01=branch compare, 10=funct-decoded.
- `pc_write` out 1: PC load enable.
- `pc_source` out 2: 0=PC+4, 1=ALUOut, 2=live ALU result.
- `reg_write` out 1: register file write enable.
- `wb_sel` out 2: writeback source; 0=ALUOut, 1=MDR, 2=PC+4.
- `is_ecall` out 1, `is_halted` out 1, `mem_err` out 1: ecall, halt and error status.
- `retire` out 1: one-cycle pulse when an instruction completes.
- `cycle_count` out PERF_WIDTH, `retire_count` out PERF_WIDTH: performance counters.

## Operation
- States and encodings: IF=0, ID=1, EX=2, MEM=3, WB=4, HALT=5, ERR=6. Registered state plus a wait counter `wait_cnt`; all outputs are combinational from state, opcode and inputs.
- While `reset`=0:
  - state←IF, counters←0.
  - All outputs are forced to 0.
- Unlisted outputs are 0 in every state.
- IF:
  - `i_or_d`=0, `mem_read`=1.
  - If `mem_ready`: `ir_write`=1, next state ID; otherwise stay in IF.
- ID:
  - Compute the branch/jump target: `alu_src_a`=0, `alu_src_b`=2, `alu_op`=00, result into ALUOut.
  - ECALL:
    - `is_ecall`=1.
    - If `halt_req`: `retire`=1, next state HALT.
    - Otherwise: `pc_write`=1, `pc_source`=0, `retire`=1, next state IF.
  - Any other opcode: next state EX.
- EX, by opcode:
  - ARITHMETIC: a=1, b=0, op=10 → WB.
  - ARITHMETIC_IMM: a=1, b=2, op=10 → WB.
  - LOAD, STORE: a=1, b=2, op=00 → MEM.
  - BRANCH: a=1, b=0, op=01, `pc_write`=1, `pc_source`=`alu_bcond`?1:0, `retire`=1 → IF.
  - JAL: `pc_write`=1, `pc_source`=1, `reg_write`=1, `wb_sel`=2, `retire`=1 → IF.
  - JALR: a=1, b=2, op=00, `pc_write`=1, `pc_source`=2, `reg_write`=1, `wb_sel`=2, `retire`=1 → IF.
  - Unknown opcode → ERR.
- MEM:
  - `i_or_d`=1; LOAD drives `mem_read`=1, STORE drives `mem_write`=1. Held until `mem_ready`.
  - On ready, LOAD: `ir_write`=0, next state WB. The MDR loads from the memory bus with ready.
  - On ready, STORE: `pc_write`=1, `pc_source`=0, `retire`=1 → IF.
- WB:
  - `reg_write`=1, `wb_sel`=LOAD?1:0.
  - `pc_write`=1, `pc_source`=0, `retire`=1 → IF.
- HALT: `is_halted`=1; terminal until reset.
- ERR: `mem_err`=1; terminal until reset.
- Timeout:
  - `wait_cnt` clears on every state change.
  - In IF or MEM with `mem_ready`=0: if `wait_cnt`==MEM_TIMEOUT (and MEM_TIMEOUT≠0) → ERR; otherwise `wait_cnt`+1.
  - `wait_cnt` width is clog2(MEM_TIMEOUT+1).

## Timing
- Latency with a zero-wait memory:
  - R/I-type: 4 cycles.
  - LOAD: 5 cycles.
  - STORE: 4 cycles.
  - BRANCH, JAL, JALR: 3 cycles.
  - ECALL: 2 cycles.
- Every memory wait cycle adds one cycle to the instruction.
- `mem_ready` is sampled only in IF and MEM; it is ignored in every other state.
- Simultaneous `mem_ready` and timeout expiry: ready wins, and the FSM advances normally.
- `reset` asserted mid-instruction: on the next edge the FSM is in IF with counters cleared. No partial strobe persists.
- JAL and JALR write rd and the PC on the same edge; PC+4 comes from the old PC.

## Configuration
- `MC_CTRL_PERF_EN`:
  - Defined: `cycle_count` increments every cycle out of reset while not in HALT or ERR. `retire_count` increments on each `retire`. Both wrap at 2^PERF_WIDTH.
  - Undefined: both ports are tied to 0 and no counter flops are built.

## Test plan
- Reset, then an `add` with `mem_ready` held 1 → states IF, ID, EX, WB. `reg_write`=1 only in cycle 4, and `retire` pulses in cycle 4.
- `lw` with `mem_ready` low for 2 cycles in MEM → 7 cycles total, WB asserts `wb_sel`=1, and `retire_count` increments by 1.
- `beq` with `alu_bcond`=1, then with 0 → 3 cycles each, `pc_source`=1, then 0.
- MEM_TIMEOUT=3 and `mem_ready` held 0 in IF → ERR entered after 4 not-ready cycles, `mem_err`=1 and sticky.
- ECALL with `halt_req`=1 → HALT after 2 cycles, `is_halted`=1, and `cycle_count` frozen.
- `reset`=0 asserted in MEM of a `sw` → `mem_write`=0 in the same cycle, state IF after the edge, no `retire`.

Source files
------------

// File: rtl/multicycle_control_unit_if.sv
// Bundle of signals between the multicycle control FSM and the RV32I
// datapath/memory it sequences. The control unit is the master: it consumes
// the instruction opcode, branch condition, memory handshake and halt request,
// and drives every datapath strobe, status flag and performance counter.
interface multicycle_control_unit_if #(
   parameter int PERF_WIDTH = 32
);
   // Datapath / memory -> control
   logic [6:0]            opcode;
   logic                  alu_bcond;
   logic                  mem_ready;
   logic                  halt_req;

   // Control -> datapath / memory
   logic                  i_or_d;
   logic                  mem_read;
   logic                  mem_write;
   logic                  ir_write;
   logic                  alu_src_a;
   logic [1:0]            alu_src_b;
   logic [1:0]            alu_op;
   logic                  pc_write;
   logic [1:0]            pc_source;
   logic                  reg_write;
   logic [1:0]            wb_sel;

   // Status and performance
   logic                  is_ecall;
   logic                  is_halted;
   logic                  mem_err;
   logic                  retire;
   logic [PERF_WIDTH-1:0] cycle_count;
   logic [PERF_WIDTH-1:0] retire_count;

   modport master (
      input  opcode, alu_bcond, mem_ready, halt_req,
      output i_or_d, mem_read, mem_write, ir_write, alu_src_a, alu_src_b,
             alu_op, pc_write, pc_source, reg_write, wb_sel,
             is_ecall, is_halted, mem_err, retire, cycle_count, retire_count
   );

   modport slave (
      output opcode, alu_bcond, mem_ready, halt_req,
      input  i_or_d, mem_read, mem_write, ir_write, alu_src_a, alu_src_b,
             alu_op, pc_write, pc_source, reg_write, wb_sel,
             is_ecall, is_halted, mem_err, retire, cycle_count, retire_count
   );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multicycle RV32I control unit. A registered state machine walks each
// instruction through IF, ID, EX, MEM and WB, waiting on a shared
// instruction/data memory ready handshake. Every strobe is decoded
// combinationally from the current state, the opcode and the inputs, and is
// forced to 0 while reset is asserted. Memory stalls in IF/MEM are bounded by
// MEM_TIMEOUT (0 disables the bound); expiry parks the FSM in ERR. An ECALL
// with halt_req parks it in HALT. Both are left only through reset.
//
// Optional feature: define MC_CTRL_PERF_EN to build the cycle and retire
// counters; without it both counter ports are tied to 0.
module multicycle_control_unit #(
   parameter int MEM_TIMEOUT = 15,
   parameter int PERF_WIDTH  = 32
) (
   input  logic                     clk,
   input  logic                     reset,
   multicycle_control_unit_if.master ctrl
);

   typedef enum logic [2:0] {
      S_IF   = 3'd0,
      S_ID   = 3'd1,
      S_EX   = 3'd2,
      S_MEM  = 3'd3,
      S_WB   = 3'd4,
      S_HALT = 3'd5,
      S_ERR  = 3'd6
   } state_t;

   // RV32I major opcodes (IR[6:0])
   localparam logic [6:0] OP_ARITH     = 7'b0110011;
   localparam logic [6:0] OP_ARITH_IMM = 7'b0010011;
   localparam logic [6:0] OP_LOAD      = 7'b0000011;
   localparam logic [6:0] OP_STORE     = 7'b0100011;
   localparam logic [6:0] OP_BRANCH    = 7'b1100011;
   localparam logic [6:0] OP_JAL       = 7'b1101111;
   localparam logic [6:0] OP_JALR      = 7'b1100111;
   localparam logic [6:0] OP_SYSTEM    = 7'b1110011;

   // Datapath select encodings
   localparam logic       SRC_A_PC     = 1'b0;
   localparam logic       SRC_A_RS1    = 1'b1;
   localparam logic [1:0] SRC_B_RS2    = 2'd0;
   localparam logic [1:0] SRC_B_IMM    = 2'd2;
   localparam logic [1:0] ALU_ADD      = 2'b00;
   localparam logic [1:0] ALU_BRANCH   = 2'b01;
   localparam logic [1:0] ALU_FUNCT    = 2'b10;
   localparam logic [1:0] PC_PLUS4     = 2'd0;
   localparam logic [1:0] PC_ALUOUT    = 2'd1;
   localparam logic [1:0] PC_ALU_LIVE  = 2'd2;
   localparam logic [1:0] WB_ALUOUT    = 2'd0;
   localparam logic [1:0] WB_MDR       = 2'd1;
   localparam logic [1:0] WB_PC4       = 2'd2;

   // Stall counter sized to reach MEM_TIMEOUT; kept at least one bit wide
   // so the disabled configuration still elaborates.
   localparam int               WAIT_W   = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
   localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);
   localparam logic             TIMEOUT_EN = (MEM_TIMEOUT != 0);

   state_t              state;
   state_t              state_next;
   logic [WAIT_W-1:0]   wait_cnt;

   logic                is_load;
   logic                is_store;
   logic                mem_wait;
   logic                timeout_hit;

   logic                i_or_d;
   logic                mem_read;
   logic                mem_write;
   logic                ir_write;
   logic                alu_src_a;
   logic [1:0]          alu_src_b;
   logic [1:0]          alu_op;
   logic                pc_write;
   logic [1:0]          pc_source;
   logic                reg_write;
   logic [1:0]          wb_sel;
   logic                is_ecall;
   logic                is_halted;
   logic                mem_err;
   logic                retire;

   assign is_load     = (ctrl.opcode == OP_LOAD);
   assign is_store    = (ctrl.opcode == OP_STORE);
   // Only the memory states wait on the handshake; ready is ignored elsewhere.
   assign mem_wait    = ((state == S_IF) || (state == S_MEM)) && !ctrl.mem_ready;
   assign timeout_hit = TIMEOUT_EN && (wait_cnt == WAIT_MAX);

   // Next-state and strobe decode from state, opcode and handshake inputs
   always_comb begin
      // NOTE: every output of this block gets a default before any branch,
      // otherwise paths that skip an assignment would infer latches.
      state_next = state;
      i_or_d     = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      alu_src_a  = SRC_A_PC;
      alu_src_b  = SRC_B_RS2;
      alu_op     = ALU_ADD;
      pc_write   = 1'b0;
      pc_source  = PC_PLUS4;
      reg_write  = 1'b0;
      wb_sel     = WB_ALUOUT;
      is_ecall   = 1'b0;
      is_halted  = 1'b0;
      mem_err    = 1'b0;
      retire     = 1'b0;

      // While reset is asserted every strobe stays at its default of 0.
      if (reset) begin
         case (state)
            S_IF: begin
               i_or_d   = 1'b0;
               mem_read = 1'b1;
               if (ctrl.mem_ready) begin
                  ir_write   = 1'b1;
                  state_next = S_ID;
               end else if (timeout_hit) begin
                  state_next = S_ERR;
               end
            end

            S_ID: begin
               // Speculative branch/jump target PC + imm into ALUOut.
               alu_src_a = SRC_A_PC;
               alu_src_b = SRC_B_IMM;
               alu_op    = ALU_ADD;
               if (ctrl.opcode == OP_SYSTEM) begin
                  is_ecall = 1'b1;
                  retire   = 1'b1;
                  if (ctrl.halt_req) begin
                     state_next = S_HALT;
                  end else begin
                     pc_write   = 1'b1;
                     pc_source  = PC_PLUS4;
                     state_next = S_IF;
                  end
               end else begin
                  state_next = S_EX;
               end
            end

            S_EX: begin
               case (ctrl.opcode)
                  OP_ARITH: begin
                     alu_src_a  = SRC_A_RS1;
                     alu_src_b  = SRC_B_RS2;
                     alu_op     = ALU_FUNCT;
                     state_next = S_WB;
                  end
                  OP_ARITH_IMM: begin
                     alu_src_a  = SRC_A_RS1;
                     alu_src_b  = SRC_B_IMM;
                     alu_op     = ALU_FUNCT;
                     state_next = S_WB;
                  end
                  OP_LOAD, OP_STORE: begin
                     alu_src_a  = SRC_A_RS1;
                     alu_src_b  = SRC_B_IMM;
                     alu_op     = ALU_ADD;
                     state_next = S_MEM;
                  end
                  OP_BRANCH: begin
                     alu_src_a  = SRC_A_RS1;
                     alu_src_b  = SRC_B_RS2;
                     alu_op     = ALU_BRANCH;
                     pc_write   = 1'b1;
                     pc_source  = ctrl.alu_bcond ? PC_ALUOUT : PC_PLUS4;
                     retire     = 1'b1;
                     state_next = S_IF;
                  end
                  OP_JAL: begin
                     // Target was computed in ID; rd gets the old PC + 4.
                     pc_write   = 1'b1;
                     pc_source  = PC_ALUOUT;
                     reg_write  = 1'b1;
                     wb_sel     = WB_PC4;
                     retire     = 1'b1;
                     state_next = S_IF;
                  end
                  OP_JALR: begin
                     // rs1 + imm is taken live from the ALU this cycle.
                     alu_src_a  = SRC_A_RS1;
                     alu_src_b  = SRC_B_IMM;
                     alu_op     = ALU_ADD;
                     pc_write   = 1'b1;
                     pc_source  = PC_ALU_LIVE;
                     reg_write  = 1'b1;
                     wb_sel     = WB_PC4;
                     retire     = 1'b1;
                     state_next = S_IF;
                  end
                  default: begin
                     state_next = S_ERR;
                  end
               endcase
            end

            S_MEM: begin
               i_or_d = 1'b1;
               if (is_load) begin
                  mem_read = 1'b1;
                  // MDR captures the bus on ready; IR stays untouched.
                  if (ctrl.mem_ready) begin
                     state_next = S_WB;
                  end else if (timeout_hit) begin
                     state_next = S_ERR;
                  end
               end else if (is_store) begin
                  mem_write = 1'b1;
                  if (ctrl.mem_ready) begin
                     pc_write   = 1'b1;
                     pc_source  = PC_PLUS4;
                     retire     = 1'b1;
                     state_next = S_IF;
                  end else if (timeout_hit) begin
                     state_next = S_ERR;
                  end
               end else begin
                  // IR changed under a memory access: no sane way forward.
                  state_next = S_ERR;
               end
            end

            S_WB: begin
               reg_write  = 1'b1;
               wb_sel     = is_load ? WB_MDR : WB_ALUOUT;
               pc_write   = 1'b1;
               pc_source  = PC_PLUS4;
               retire     = 1'b1;
               state_next = S_IF;
            end

            S_HALT: begin
               is_halted = 1'b1;
            end

            S_ERR: begin
               mem_err = 1'b1;
            end

            default: begin
               state_next = S_ERR;
            end
         endcase
      end
   end

   // State register and memory stall counter, synchronous active-low reset
   always_ff @(posedge clk) begin
      // NOTE: registers are updated with <= so every flop samples the values
      // from before this edge, independent of statement order.
      if (!reset) begin
         state    <= S_IF;
         wait_cnt <= '0;
      end else begin
         state <= state_next;
         if (state_next != state) begin
            wait_cnt <= '0;
         end else if (mem_wait) begin
            wait_cnt <= wait_cnt + 1'b1;
         end
      end
   end

   assign ctrl.i_or_d    = i_or_d;
   assign ctrl.mem_read  = mem_read;
   assign ctrl.mem_write = mem_write;
   assign ctrl.ir_write  = ir_write;
   assign ctrl.alu_src_a = alu_src_a;
   assign ctrl.alu_src_b = alu_src_b;
   assign ctrl.alu_op    = alu_op;
   assign ctrl.pc_write  = pc_write;
   assign ctrl.pc_source = pc_source;
   assign ctrl.reg_write = reg_write;
   assign ctrl.wb_sel    = wb_sel;
   assign ctrl.is_ecall  = is_ecall;
   assign ctrl.is_halted = is_halted;
   assign ctrl.mem_err   = mem_err;
   assign ctrl.retire    = retire;

`ifdef MC_CTRL_PERF_EN
   logic [PERF_WIDTH-1:0] cycle_q;
   logic [PERF_WIDTH-1:0] retire_q;

   // Active-cycle and retirement counters; both freeze in HALT/ERR and wrap
   always_ff @(posedge clk) begin
      if (!reset) begin
         cycle_q  <= '0;
         retire_q <= '0;
      end else begin
         if ((state != S_HALT) && (state != S_ERR)) begin
            cycle_q <= cycle_q + 1'b1;
         end
         if (retire) begin
            retire_q <= retire_q + 1'b1;
         end
      end
   end

   assign ctrl.cycle_count  = reset ? cycle_q  : {PERF_WIDTH{1'b0}};
   assign ctrl.retire_count = reset ? retire_q : {PERF_WIDTH{1'b0}};
`else
   assign ctrl.cycle_count  = {PERF_WIDTH{1'b0}};
   assign ctrl.retire_count = {PERF_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench for multicycle_control_unit. A driver applies one directed
// input vector per cycle and queues the hand-computed strobe set and counter
// values for that cycle; a monitor on the falling edge pops and compares.
module tb_multicycle_control_unit;

   localparam int PW  = 32;
   localparam int TMO = 3;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LW     = 7'b0000011;
   localparam logic [6:0] OP_SW     = 7'b0100011;
   localparam logic [6:0] OP_BEQ    = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_ECALL  = 7'b1110011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;

   typedef struct packed {
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic       pc_write;
      logic [1:0] pc_source;
      logic       reg_write;
      logic [1:0] wb_sel;
      logic       is_ecall;
      logic       is_halted;
      logic       mem_err;
      logic       retire;
   } ctrl_t;

   typedef struct packed {
      ctrl_t          ctrl;
      logic [PW-1:0]  cyc;
      logic [PW-1:0]  ret;
      logic [15:0]    id;
   } exp_t;

   localparam ctrl_t C_ZERO        = '0;
   localparam ctrl_t C_IF_WAIT     = '{mem_read: 1'b1, default: '0};
   localparam ctrl_t C_IF_RDY      = '{mem_read: 1'b1, ir_write: 1'b1, default: '0};
   localparam ctrl_t C_ID          = '{alu_src_b: 2'd2, default: '0};
   localparam ctrl_t C_ID_ECALL    = '{alu_src_b: 2'd2, is_ecall: 1'b1, pc_write: 1'b1, retire: 1'b1, default: '0};
   localparam ctrl_t C_ID_HALT     = '{alu_src_b: 2'd2, is_ecall: 1'b1, retire: 1'b1, default: '0};
   localparam ctrl_t C_EX_R        = '{alu_src_a: 1'b1, alu_op: 2'b10, default: '0};
   localparam ctrl_t C_EX_I        = '{alu_src_a: 1'b1, alu_src_b: 2'd2, alu_op: 2'b10, default: '0};
   localparam ctrl_t C_EX_LS       = '{alu_src_a: 1'b1, alu_src_b: 2'd2, default: '0};
   localparam ctrl_t C_EX_BT       = '{alu_src_a: 1'b1, alu_op: 2'b01, pc_write: 1'b1, pc_source: 2'd1, retire: 1'b1, default: '0};
   localparam ctrl_t C_EX_BN       = '{alu_src_a: 1'b1, alu_op: 2'b01, pc_write: 1'b1, retire: 1'b1, default: '0};
   localparam ctrl_t C_EX_JAL      = '{pc_write: 1'b1, pc_source: 2'd1, reg_write: 1'b1, wb_sel: 2'd2, retire: 1'b1, default: '0};
   localparam ctrl_t C_EX_JALR     = '{alu_src_a: 1'b1, alu_src_b: 2'd2, pc_write: 1'b1, pc_source: 2'd2, reg_write: 1'b1, wb_sel: 2'd2, retire: 1'b1, default: '0};
   localparam ctrl_t C_MEM_LD      = '{i_or_d: 1'b1, mem_read: 1'b1, default: '0};
   localparam ctrl_t C_MEM_ST_WAIT = '{i_or_d: 1'b1, mem_write: 1'b1, default: '0};
   localparam ctrl_t C_MEM_ST_DONE = '{i_or_d: 1'b1, mem_write: 1'b1, pc_write: 1'b1, retire: 1'b1, default: '0};
   localparam ctrl_t C_WB_ALU      = '{reg_write: 1'b1, pc_write: 1'b1, retire: 1'b1, default: '0};
   localparam ctrl_t C_WB_LD       = '{reg_write: 1'b1, wb_sel: 2'd1, pc_write: 1'b1, retire: 1'b1, default: '0};
   localparam ctrl_t C_HALT        = '{is_halted: 1'b1, default: '0};
   localparam ctrl_t C_ERR         = '{mem_err: 1'b1, default: '0};

   logic clk;
   logic reset;

   multicycle_control_unit_if #(.PERF_WIDTH(PW)) bus ();

   multicycle_control_unit #(
      .MEM_TIMEOUT (TMO),
      .PERF_WIDTH  (PW)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .ctrl  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   exp_t          sb_q[$];
   string         tag_q[$];
   int            total = 0;
   int            bad   = 0;
   int            step_n = 0;
   logic [PW-1:0] m_cyc = '0;
   logic [PW-1:0] m_ret = '0;

   task automatic check(input string name, input int id, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s step=%0d got=%h want=%h", name, id, act, exp);
      end
   endtask

   // One cycle of stimulus: apply inputs, queue the expected response, then
   // advance to just after the next rising edge.
   task automatic drive(input string tag, input logic rst, input logic [6:0] op,
                        input logic bcond, input logic rdy, input logic halt,
                        input ctrl_t exp);
      exp_t e;
      reset          = rst;
      bus.opcode     = op;
      bus.alu_bcond  = bcond;
      bus.mem_ready  = rdy;
      bus.halt_req   = halt;
      e.ctrl = exp;
      e.id   = 16'(step_n);
`ifdef MC_CTRL_PERF_EN
      e.cyc  = rst ? m_cyc : '0;
      e.ret  = rst ? m_ret : '0;
`else
      e.cyc  = '0;
      e.ret  = '0;
`endif
      sb_q.push_back(e);
      tag_q.push_back(tag);
      if (!rst) begin
         m_cyc = '0;
         m_ret = '0;
      end else begin
         if (!exp.is_halted && !exp.mem_err) m_cyc = m_cyc + 1;
         if (exp.retire) m_ret = m_ret + 1;
      end
      step_n++;
      @(posedge clk);
      #1;
   endtask

   // Monitor: compare the live outputs against the queued expectation
   always @(negedge clk) begin
      exp_t  e;
      string t;
      ctrl_t act;
      if (sb_q.size() > 0) begin
         e   = sb_q.pop_front();
         t   = tag_q.pop_front();
         act = {bus.i_or_d, bus.mem_read, bus.mem_write, bus.ir_write, bus.alu_src_a,
                bus.alu_src_b, bus.alu_op, bus.pc_write, bus.pc_source, bus.reg_write,
                bus.wb_sel, bus.is_ecall, bus.is_halted, bus.mem_err, bus.retire};
         check({t, " ctrl"},         int'(e.id), 64'(act),              64'(e.ctrl));
         check({t, " cycle_count"},  int'(e.id), 64'(bus.cycle_count),  64'(e.cyc));
         check({t, " retire_count"}, int'(e.id), 64'(bus.retire_count), 64'(e.ret));
      end
   end

   initial begin
      reset         = 1'b0;
      bus.opcode    = OP_R;
      bus.alu_bcond = 1'b0;
      bus.mem_ready = 1'b0;
      bus.halt_req  = 1'b0;
      @(posedge clk);
      #1;

      // Reset holds every output at 0 even with ready high
      drive("reset0", 1'b0, OP_R, 1'b0, 1'b1, 1'b0, C_ZERO);
      drive("reset1", 1'b0, OP_R, 1'b0, 1'b1, 1'b0, C_ZERO);

      // add: IF ID EX WB
      drive("add.if", 1'b1, OP_R, 1'b0, 1'b1, 1'b0, C_IF_RDY);
      drive("add.id", 1'b1, OP_R, 1'b0, 1'b1, 1'b0, C_ID);
      drive("add.ex", 1'b1, OP_R, 1'b0, 1'b1, 1'b0, C_EX_R);
      drive("add.wb", 1'b1, OP_R, 1'b0, 1'b1, 1'b0, C_WB_ALU);

      // addi
      drive("addi.if", 1'b1, OP_I, 1'b0, 1'b1, 1'b0, C_IF_RDY);
      drive("addi.id", 1'b1, OP_I, 1'b0, 1'b1, 1'b0, C_ID);
      drive("addi.ex", 1'b1, OP_I, 1'b0, 1'b1, 1'b0, C_EX_I);
      drive("addi.wb", 1'b1, OP_I, 1'b0, 1'b1, 1'b0, C_WB_ALU);

      // lw: ready low in ID/EX is ignored; two wait cycles in MEM -> 7 cycles
      drive("lw.if",    1'b1, OP_LW, 1'b0, 1'b1, 1'b0, C_IF_RDY);
      drive("lw.id",    1'b1, OP_LW, 1'b0, 1'b0, 1'b0, C_ID);
      drive("lw.ex",    1'b1, OP_LW, 1'b0, 1'b0, 1'b0, C_EX_LS);
      drive("lw.mem_w", 1'b1, OP_LW, 1'b0, 1'b0, 1'b0, C_MEM_LD);
      drive("lw.mem_w", 1'b1, OP_LW, 1'b0, 1'b0, 1'b0, C_MEM_LD);
      drive("lw.mem_r", 1'b1, OP_LW, 1'b0, 1'b1, 1'b0, C_MEM_LD);
      drive("lw.wb",    1'b1, OP_LW, 1'b0, 1'b0, 1'b0, C_WB_LD);

      // beq taken then not taken
      drive("beqT.if", 1'b1, OP_BEQ, 1'b0, 1'b1, 1'b0, C_IF_RDY);
      drive("beqT.id", 1'b1, OP_BEQ, 1'b0, 1'b1, 1'b0, C_ID);
      drive("beqT.ex", 1'b1, OP_BEQ, 1'b1, 1'b1, 1'b0, C_EX_BT);
      drive("beqN.if", 1'b1, OP_BEQ, 1'b0, 1'b1, 1'b0, C_IF_RDY);
      drive("beqN.id", 1'b1, OP_BEQ, 1'b0, 1'b1, 1'b0, C_ID);
      drive("beqN.ex", 1'b1, OP_BEQ, 1'b0, 1'b1, 1'b0, C_EX_BN);

      // jal, jalr
      drive("jal.if",  1'b1, OP_JAL,  1'b0, 1'b1, 1'b0, C_IF_RDY);
      drive("jal.id",  1'b1, OP_JAL,  1'b0, 1'b1, 1'b0, C_ID);
      drive("jal.ex",  1'b1, OP_JAL,  1'b0, 1'b1, 1'b0, C_EX_JAL);
      drive("jalr.if", 1'b1, OP_JALR, 1'b0, 1'b1, 1'b0, C_IF_RDY);
      drive("jalr.id", 1'b1, OP_JALR, 1'b0, 1'b1, 1'b0, C_ID);
      drive("jalr.ex", 1'b1, OP_JALR, 1'b0, 1'b1, 1'b0, C_EX_JALR);

      // sw: three IF stalls, then ready on the expiry cycle wins
      for (int i = 0; i < TMO; i++)
         drive("sw.if_w", 1'b1, OP_SW, 1'b0, 1'b0, 1'b0, C_IF_WAIT);
      drive("sw.if_r",   1'b1, OP_SW, 1'b0, 1'b1, 1'b0, C_IF_RDY);
      drive("sw.id",     1'b1, OP_SW, 1'b0, 1'b1, 1'b0, C_ID);
      drive("sw.ex",     1'b1, OP_SW, 1'b0, 1'b1, 1'b0, C_EX_LS);
      drive("sw.mem_w",  1'b1, OP_SW, 1'b0, 1'b0, 1'b0, C_MEM_ST_WAIT);
      drive("sw.mem_r",  1'b1, OP_SW, 1'b0, 1'b1, 1'b0, C_MEM_ST_DONE);

      // ecall without halt
      drive("ecall.if", 1'b1, OP_ECALL, 1'b0, 1'b1, 1'b0, C_IF_RDY);
      drive("ecall.id", 1'b1, OP_ECALL, 1'b0, 1'b1, 1'b0, C_ID_ECALL);

      // sw interrupted by reset in MEM: strobes drop at once, restart in IF
      drive("swr.if",    1'b1, OP_SW, 1'b0, 1'b1, 1'b0, C_IF_RDY);
      drive("swr.id",    1'b1, OP_SW, 1'b0, 1'b1, 1'b0, C_ID);
      drive("swr.ex",    1'b1, OP_SW, 1'b0, 1'b1, 1'b0, C_EX_LS);
      drive("swr.mem_w", 1'b1, OP_SW, 1'b0, 1'b0, 1'b0, C_MEM_ST_WAIT);
      drive("swr.rst",   1'b0, OP_SW, 1'b0, 1'b1, 1'b0, C_ZERO);
      drive("swr.if_w",  1'b1, OP_R,  1'b0, 1'b0, 1'b0, C_IF_WAIT);
      drive("swr.if_r",  1'b1, OP_R,  1'b0, 1'b1, 1'b0, C_IF_RDY);
      drive("swr.id",    1'b1, OP_R,  1'b0, 1'b1, 1'b0, C_ID);
      drive("swr.ex",    1'b1, OP_R,  1'b0, 1'b1, 1'b0, C_EX_R);
      drive("swr.wb",    1'b1, OP_R,  1'b0, 1'b1, 1'b0, C_WB_ALU);

      // Unknown opcode in EX -> ERR, sticky until reset
      drive("lui.if",  1'b1, OP_LUI, 1'b0, 1'b1, 1'b0, C_IF_RDY);
      drive("lui.id",  1'b1, OP_LUI, 1'b0, 1'b1, 1'b0, C_ID);
      drive("lui.ex",  1'b1, OP_LUI, 1'b0, 1'b1, 1'b0, C_ZERO);
      drive("lui.err", 1'b1, OP_LUI, 1'b0, 1'b1, 1'b0, C_ERR);
      drive("lui.err", 1'b1, OP_R,   1'b0, 1'b1, 1'b0, C_ERR);
      drive("lui.rst", 1'b0, OP_R,   1'b0, 1'b0, 1'b0, C_ZERO);

      // IF timeout: TMO+1 not-ready cycles, then sticky ERR despite ready
      for (int i = 0; i <= TMO; i++)
         drive("tmo.if_w", 1'b1, OP_R, 1'b0, 1'b0, 1'b0, C_IF_WAIT);
      drive("tmo.err", 1'b1, OP_R, 1'b0, 1'b1, 1'b0, C_ERR);
      drive("tmo.err", 1'b1, OP_R, 1'b0, 1'b1, 1'b0, C_ERR);
      drive("tmo.rst", 1'b0, OP_R, 1'b0, 1'b1, 1'b0, C_ZERO);

      // ecall with halt: HALT after two cycles, cycle counter frozen
      drive("halt.if", 1'b1, OP_ECALL, 1'b0, 1'b1, 1'b1, C_IF_RDY);
      drive("halt.id", 1'b1, OP_ECALL, 1'b0, 1'b1, 1'b1, C_ID_HALT);
      for (int i = 0; i < 3; i++)
         drive("halt.halt", 1'b1, OP_R, 1'b0, 1'b1, 1'b0, C_HALT);

      // Drain the scoreboard within a bounded number of cycles
      for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
      if (sb_q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL drain pending=%0d want=0", sb_q.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
